// File: rtl/token_merge_arb.sv
// token_merge_arb: merges two 4-phase upstream token channels onto one downstream channel, round-robin on ties.
// Grant/Ack 1 cycle after request; losers wait with Ack low until IDLE; watchdog flags a stalled downstream.

module token_merge_arb #(
  parameter int DW      = 32,
  parameter int CW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          Send_in_a,
  input  logic          Send_in_b,
  input  logic [DW-1:0] Data_in_a,
  input  logic [DW-1:0] Data_in_b,
  output logic          Ack_out_a,
  output logic          Ack_out_b,
  output logic          Send_out,
  output logic [DW-1:0] Data_out,
  input  logic          Ack_in,
  output logic          Grant_id,
  output logic          Busy,
  output logic [CW-1:0] Tok_cnt,
  output logic          Err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP_WAIT = 2'd1,
    DN_HI   = 2'd2,
    DN_LO   = 2'd3
  } state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            gid_q, gid_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic            send_q, send_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     wd_q, wd_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            gnt;
  logic            src_req;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_a_d = ack_a_q;
    ack_b_d = ack_b_q;
    send_d  = send_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    err_d   = err_q;
    // On a tie the source the pointer does not name wins; a lone request wins outright.
    gnt     = (Send_in_a && Send_in_b) ? ~ptr_q : Send_in_b;
    src_req = gid_q ? Send_in_b : Send_in_a;

    case (state_q)
      IDLE: begin
        if (Send_in_a || Send_in_b) begin
          state_d = UP_WAIT;
          dat_d   = gnt ? Data_in_b : Data_in_a;
          ack_a_d = ~gnt;
          ack_b_d = gnt;
          gid_d   = gnt;
          ptr_d   = gnt;
        end
      end
      UP_WAIT: begin
        if (!src_req) begin
          state_d = DN_HI;
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          send_d  = 1'b1;
          wd_d    = '0;
        end
      end
      DN_HI: begin
        if (Ack_in) begin
          state_d = DN_LO;
          send_d  = 1'b0;
        end
      end
      DN_LO: begin
        if (!Ack_in) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog observes the downstream phases only; it never alters the handshake.
    if (state_q == DN_HI || state_q == DN_LO) begin
      if (wd_q != WD_LIMIT) begin
        wd_d = wd_q + 16'd1;
      end
      if (wd_d == WD_LIMIT) begin
        err_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      gid_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      send_q  <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      send_q  <= send_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign Ack_out_a = ack_a_q;
  assign Ack_out_b = ack_b_q;
  assign Send_out  = send_q;
  assign Data_out  = dat_q;
  assign Grant_id  = gid_q;
  assign Busy      = busy_q;
  assign Tok_cnt   = cnt_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_token_merge_arb.sv
// Bench for token_merge_arb: acts as both upstream sources and the downstream stage,
// predicting grants, counts and the timeout flag from a transaction-level model.

module tb_token_merge_arb;

  localparam int P_DW = 32;
  localparam int P_CW = 2;
  localparam int P_TO = 5;

  logic            CLK = 1'b0;
  logic            MR, send_a, send_b, ack_in;
  logic [P_DW-1:0] din_a, din_b, dout;
  logic            ack_a, ack_b, send_out, gid, busy, err;
  logic [P_CW-1:0] tok;

  int total = 0;
  int bad   = 0;
  bit both_seen = 1'b0;

  // Transaction-level model state
  int m_cnt;
  bit m_ptr;
  bit m_err;

  always #5 CLK = ~CLK;

  token_merge_arb #(.DW(P_DW), .CW(P_CW), .TIMEOUT(P_TO)) dut (
    .CLK(CLK), .MR(MR),
    .Send_in_a(send_a), .Send_in_b(send_b),
    .Data_in_a(din_a), .Data_in_b(din_b),
    .Ack_out_a(ack_a), .Ack_out_b(ack_b),
    .Send_out(send_out), .Data_out(dout), .Ack_in(ack_in),
    .Grant_id(gid), .Busy(busy), .Tok_cnt(tok), .Err(err)
  );

  always @(negedge CLK) begin
    if (ack_a === 1'b1 && ack_b === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    MR = 1'b1; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0;
    din_a = '0; din_b = '0;
    step();
    MR = 1'b0;
    m_cnt = 0; m_ptr = 1'b1; m_err = 1'b0;
  endtask

  task automatic grant_phase(input bit ra, input bit rb, input logic [P_DW-1:0] da,
                             input logic [P_DW-1:0] db, output logic o_aa, output logic o_ab,
                             output logic o_gid, output logic o_busy, output logic [P_DW-1:0] o_dat);
    send_a = ra; send_b = rb; din_a = da; din_b = db;
    step();
    o_aa = ack_a; o_ab = ack_b; o_gid = gid; o_busy = busy; o_dat = dout;
  endtask

  task automatic up_release(input bit src, input int hold, output logic o_send,
                            output logic o_aa, output logic o_ab, output logic [P_DW-1:0] o_dat);
    repeat (hold) step();
    if (src) send_b = 1'b0; else send_a = 1'b0;
    step();
    o_send = send_out; o_aa = ack_a; o_ab = ack_b; o_dat = dout;
  endtask

  task automatic dn_phase(input int w, input int h, output logic o_lo_send, output logic o_busy,
                          output logic [P_CW-1:0] o_tok, output logic o_err);
    ack_in = 1'b0;
    repeat (w) step();
    ack_in = 1'b1;
    step();
    o_lo_send = send_out;
    repeat (h) step();
    ack_in = 1'b0;
    step();
    o_busy = busy; o_tok = tok; o_err = err;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ack_a, ack_b, send_out, gid, busy, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000", {ack_a, ack_b, send_out, gid, busy, err});
    end
    total++;
    if (dout !== '0 || tok !== '0) begin
      bad++;
      $display("FAIL reset_data_cnt: got dout=%h tok=%0d want 0/0", dout, tok);
    end
  endtask

  task automatic test_single_a();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d;
    logic [P_CW-1:0] t;
    do_reset();
    grant_phase(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, aa, ab, g, b, d);
    total++;
    if ({aa, ab, g, b} !== 4'b1001 || d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_grant: got aa=%b ab=%b gid=%b busy=%b d=%h want 1 0 0 1 deadbeef", aa, ab, g, b, d);
    end
    up_release(1'b0, 1, s, aa, ab, d);
    total++;
    if (s !== 1'b1 || aa !== 1'b0 || d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_send: got send=%b ack_a=%b d=%h want 1 0 deadbeef", s, aa, d);
    end
    dn_phase(1, 1, lo, b, t, e);
    total++;
    if (lo !== 1'b0 || b !== 1'b0 || t !== 2'd1 || gid !== 1'b0 || e !== 1'b0) begin
      bad++;
      $display("FAIL single_done: got lo=%b busy=%b tok=%0d gid=%b err=%b want 0 0 1 0 0", lo, b, t, gid, e);
    end
  endtask

  task automatic test_round_robin();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d, da, db;
    logic [P_CW-1:0] t;
    bit exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    both_seen = 1'b0;
    da = $urandom; db = $urandom;
    for (int k = 0; k < 4; k++) begin
      grant_phase(1'b1, 1'b1, da, db, aa, ab, g, b, d);
      total++;
      if (g !== exp_g[k] || d !== (exp_g[k] ? db : da) || aa !== ~exp_g[k] || ab !== exp_g[k]) begin
        bad++;
        $display("FAIL rr_grant%0d: got gid=%b d=%h aa=%b ab=%b want gid=%b", k, g, d, aa, ab, exp_g[k]);
      end
      up_release(exp_g[k], $urandom_range(1, 0), s, aa, ab, d);
      // Released source re-requests at once with a fresh token.
      if (exp_g[k]) begin db = $urandom; din_b = db; send_b = 1'b1; end
      else begin da = $urandom; din_a = da; send_a = 1'b1; end
      dn_phase(0, 0, lo, b, t, e);
      total++;
      if (t !== 2'(k + 1) || ack_a !== 1'b0 || ack_b !== 1'b0) begin
        bad++;
        $display("FAIL rr_cnt%0d: got tok=%0d aa=%b ab=%b want %0d 0 0", k, t, ack_a, ack_b, (k + 1) % 4);
      end
    end
    send_a = 1'b0; send_b = 1'b0;
    total++;
    if (both_seen !== 1'b0) begin
      bad++;
      $display("FAIL rr_exclusive_ack: got both_seen=%b want 0", both_seen);
    end
  endtask

  task automatic test_timeout();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d;
    logic [P_CW-1:0] t;
    do_reset();
    grant_phase(1'b1, 1'b0, $urandom, 32'h0, aa, ab, g, b, d);
    up_release(1'b0, 0, s, aa, ab, d);
    repeat (P_TO - 1) step();
    total++;
    if (err !== 1'b0 || send_out !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got err=%b send=%b want 0 1", err, send_out);
    end
    step();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_set: got err=%b want 1", err);
    end
    dn_phase(0, 0, lo, b, t, e);
    total++;
    if (b !== 1'b0 || e !== 1'b1 || t !== 2'd1) begin
      bad++;
      $display("FAIL timeout_after: got busy=%b err=%b tok=%0d want 0 1 1", b, e, t);
    end
    do_reset();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got err=%b want 0", err);
    end
  endtask

  task automatic test_mr_abort();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d;
    logic [P_CW-1:0] t;
    do_reset();
    grant_phase(1'b0, 1'b1, 32'h0, $urandom, aa, ab, g, b, d);
    up_release(1'b1, 0, s, aa, ab, d);
    step(); step();
    MR = 1'b1;
    step();
    MR = 1'b0;
    total++;
    if (send_out !== 1'b0 || busy !== 1'b0 || tok !== '0 || err !== 1'b0 || dout !== '0 || gid !== 1'b0) begin
      bad++;
      $display("FAIL mr_abort: got send=%b busy=%b tok=%0d err=%b dout=%h gid=%b want all 0",
               send_out, busy, tok, err, dout, gid);
    end
    m_cnt = 0; m_ptr = 1'b1; m_err = 1'b0;
    grant_phase(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, aa, ab, g, b, d);
    total++;
    if (g !== 1'b0 || d !== 32'h1111_2222) begin
      bad++;
      $display("FAIL mr_tie_a: got gid=%b d=%h want 0 11112222", g, d);
    end
    send_b = 1'b0;
    up_release(1'b0, 0, s, aa, ab, d);
    dn_phase(0, 0, lo, b, t, e);
    total++;
    if (t !== 2'd1) begin
      bad++;
      $display("FAIL mr_not_counted: got tok=%0d want 1", t);
    end
  endtask

  task automatic test_ignore();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d, tb_dat;
    logic [P_CW-1:0] t;
    do_reset();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    total++;
    if (busy !== 1'b0 || send_out !== 1'b0 || tok !== '0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      bad++;
      $display("FAIL ign_idle_ack: got busy=%b send=%b tok=%0d want 0 0 0", busy, send_out, tok);
    end
    grant_phase(1'b1, 1'b0, $urandom, 32'h0, aa, ab, g, b, d);
    ack_in = 1'b1;
    tb_dat = $urandom;
    din_b = tb_dat; send_b = 1'b1;
    step();
    ack_in = 1'b0;
    total++;
    if (send_out !== 1'b0 || ack_a !== 1'b1 || busy !== 1'b1 || ack_b !== 1'b0) begin
      bad++;
      $display("FAIL ign_upwait: got send=%b aa=%b busy=%b ab=%b want 0 1 1 0", send_out, ack_a, busy, ack_b);
    end
    up_release(1'b0, 0, s, aa, ab, d);
    total++;
    if (ab !== 1'b0 || s !== 1'b1) begin
      bad++;
      $display("FAIL ign_b_during_a: got ab=%b send=%b want 0 1", ab, s);
    end
    dn_phase(1, 0, lo, b, t, e);
    total++;
    if (ack_b !== 1'b0 || b !== 1'b0) begin
      bad++;
      $display("FAIL ign_b_idle: got ab=%b busy=%b want 0 0", ack_b, b);
    end
    grant_phase(1'b0, 1'b1, 32'h0, tb_dat, aa, ab, g, b, d);
    total++;
    if (ab !== 1'b1 || g !== 1'b1 || d !== tb_dat || aa !== 1'b0) begin
      bad++;
      $display("FAIL ign_b_grant: got ab=%b gid=%b d=%h want 1 1 %h", ab, g, d, tb_dat);
    end
    up_release(1'b1, 0, s, aa, ab, d);
    dn_phase(0, 0, lo, b, t, e);
  endtask

  task automatic test_wrap();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d;
    logic [P_CW-1:0] t;
    logic [P_CW-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      grant_phase(1'b1, 1'b0, $urandom, 32'h0, aa, ab, g, b, d);
      up_release(1'b0, 0, s, aa, ab, d);
      dn_phase(0, 0, lo, b, t, e);
      total++;
      if (t !== exp_seq[k]) begin
        bad++;
        $display("FAIL wrap%0d: got tok=%0d want %0d", k, t, exp_seq[k]);
      end
    end
  endtask

  task automatic test_random();
    logic aa, ab, g, b, s, lo, e;
    logic [P_DW-1:0] d;
    logic [P_CW-1:0] t;
    bit pend [2];
    logic [P_DW-1:0] pdat [2];
    bit exp_g;
    int w, h;
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && $urandom_range(1, 0) == 1) begin pend[x] = 1'b1; pdat[x] = $urandom; end
      end
      if (!pend[0] && !pend[1]) begin
        int x = $urandom_range(1, 0);
        pend[x] = 1'b1; pdat[x] = $urandom;
      end
      exp_g = (pend[0] && pend[1]) ? ~m_ptr : pend[1];
      m_ptr = exp_g;
      grant_phase(pend[0], pend[1], pdat[0], pdat[1], aa, ab, g, b, d);
      total++;
      if (g !== exp_g || aa !== ~exp_g || ab !== exp_g || d !== pdat[exp_g] || b !== 1'b1) begin
        bad++;
        $display("FAIL rnd_grant%0d: got gid=%b aa=%b ab=%b d=%h want gid=%b d=%h", r, g, aa, ab, d, exp_g, pdat[exp_g]);
      end
      up_release(exp_g, $urandom_range(2, 0), s, aa, ab, d);
      pend[exp_g] = 1'b0;
      total++;
      if (s !== 1'b1 || aa !== 1'b0 || ab !== 1'b0 || d !== pdat[exp_g]) begin
        bad++;
        $display("FAIL rnd_send%0d: got send=%b aa=%b ab=%b d=%h want 1 0 0 %h", r, s, aa, ab, d, pdat[exp_g]);
      end
      w = $urandom_range(2, 0);
      h = $urandom_range(1, 0);
      dn_phase(w, h, lo, b, t, e);
      m_cnt++;
      if (w + h + 2 >= P_TO) m_err = 1'b1;
      total++;
      if (lo !== 1'b0 || b !== 1'b0 || t !== 2'(m_cnt) || e !== m_err) begin
        bad++;
        $display("FAIL rnd_done%0d: got lo=%b busy=%b tok=%0d err=%b want 0 0 %0d %b", r, lo, b, t, e, m_cnt % 4, m_err);
      end
    end
    send_a = 1'b0; send_b = 1'b0;
  endtask

  task automatic test_exclusive_ack();
    total++;
    if (both_seen !== 1'b0) begin
      bad++;
      $display("FAIL exclusive_ack: got both_seen=%b want 0", both_seen);
    end
  endtask

  initial begin
    MR = 1'b1; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0; din_a = '0; din_b = '0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_timeout();
    test_mr_abort();
    test_ignore();
    test_wrap();
    test_random();
    test_exclusive_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/token_merge_arb.md
TOKEN_MERGE_ARB -- requirements
Module: token_merge_arb

Interface
REQ-001 SHALL have parameter DW, default 32, token data width in bits.
REQ-002 SHALL have parameter CW, default 8, width of the completed-token counter.
REQ-003 SHALL have parameter TIMEOUT, default 255, downstream-wait cycles before Err is set (1..2^16-1).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port MR  input  1  master reset, synchronous, active-high.
REQ-006 SHALL have ports Send_in_a / Send_in_b  input  1  request from upstream A / B (4-phase, active-high).
REQ-007 SHALL have ports Data_in_a / Data_in_b  input  DW  token from A / B, stable while the matching Send_in is high.
REQ-008 SHALL have ports Ack_out_a / Ack_out_b  output  1  acknowledge to upstream A / B.
REQ-009 SHALL have port Send_out  output  1  request to the shared downstream stage.
REQ-010 SHALL have port Data_out  output  DW  latched token, held from capture until the next capture.
REQ-011 SHALL have port Ack_in  input  1  acknowledge from the downstream stage.
REQ-012 SHALL have port Grant_id  output  1  source of the current or last token (0=A, 1=B).
REQ-013 SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have port Tok_cnt  output  CW  count of completed downstream transfers.
REQ-015 SHALL have port Err  output  1  sticky downstream-timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, UP_WAIT, DN_HI, DN_LO; all outputs registered.
REQ-017 IDLE: if only Send_in_x=1, SHALL grant x; if both are 1, SHALL grant the source not equal to the priority pointer (round-robin).
REQ-018 On the grant edge SHALL capture Data_out<=Data_in_x, set Ack_out_x<=1, Grant_id<=x, pointer<=x, and go to UP_WAIT.
REQ-019 UP_WAIT: when Send_in_x=0, SHALL drive Ack_out_x<=0 and Send_out<=1 and go to DN_HI; otherwise hold.
REQ-020 DN_HI: when Ack_in=1, SHALL drive Send_out<=0 and go to DN_LO.
REQ-021 DN_LO: when Ack_in=0, SHALL increment Tok_cnt (wrapping mod 2^CW) and go to IDLE.
REQ-022 Latency: Ack_out_x SHALL be visible 1 cycle after the edge that samples Send_in_x=1 in IDLE; Send_out SHALL be visible 1 cycle after the edge that samples Send_in_x=0 in UP_WAIT.
REQ-023 Send_in of the non-granted source SHALL be ignored outside IDLE and its Ack_out SHALL stay 0.
REQ-024 Ack_in=1 in IDLE or UP_WAIT SHALL be ignored.
REQ-025 Data_out SHALL be stable from the grant edge until the next grant edge.
REQ-026 At most one of Ack_out_a, Ack_out_b SHALL be high in any cycle.
REQ-027 Watchdog: a counter SHALL clear on entry to DN_HI and count cycles spent in DN_HI or DN_LO; on reaching TIMEOUT it SHALL set Err=1. The counter SHALL saturate there. The FSM SHALL continue unaffected.
REQ-028 Err SHALL remain 1 until MR.
REQ-029 Busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-030 MR=1 sampled at a CLK edge SHALL force IDLE, Ack_out_a=Ack_out_b=0, Send_out=0, Data_out=0, Grant_id=0, pointer=B (so A wins the first tie), Tok_cnt=0, Err=0, watchdog=0, Busy=0.
REQ-031 MR SHALL take precedence over all events in any state, including an in-flight handshake; the aborted token SHALL not be counted.

Verification
REQ-032 Single A token 0xDEADBEEF: Ack_out_a high 1 cycle later; drop Send_in_a -> Send_out=1, Data_out=0xDEADBEEF; full downstream handshake -> Tok_cnt=1, Grant_id=0.
REQ-033 Both sources request continuously after reset for 4 tokens: grant order A,B,A,B; Tok_cnt=4; never both Ack_out high.
REQ-034 Hold Ack_in=0 in DN_HI with TIMEOUT=5: Err=1 after 5 cycles; then complete the handshake -> Busy=0, Err stays 1.
REQ-035 Assert MR while in DN_HI: next cycle Send_out=0, Busy=0, Tok_cnt unchanged, Err=0.
REQ-036 CW=2, 5 A-tokens: Tok_cnt sequence 1,2,3,0,1.
REQ-037 Ack_in pulsed high while IDLE, and Send_in_b raised during an A transfer: no state change; Ack_out_b=0 until B is granted in IDLE.
